// File: rtl/pipe_ctrl_pkg.sv
// Shared types and stage indices for the pipeline controller.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        NONE     = 3'd0,
        MEM_WAIT = 3'd1,
        EX_BUSY  = 3'd2,
        FLUSH    = 3'd3,
        LOAD_USE = 3'd4,
        IF_WAIT  = 3'd5
    } stall_cause_e;

    localparam int ST_IF   = 0;
    localparam int ST_ID   = 1;
    localparam int ST_EX   = 2;
    localparam int ST_MEM0 = 3;

    localparam int FWD_RF  = 0;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Forwarding select for one EX source: youngest valid writer in stages MEM0..WB wins.
// Purely combinational; x0 and unused sources always read the register file.
module pipe_fwd_sel
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int REG_ADDR_W = 5,
    parameter int FW         = 2
) (
    input  logic [REG_ADDR_W-1:0]                          rs,
    input  logic                                           rs_used,
    input  logic [NUM_STAGES-1:ST_MEM0]                    cand_vld,
    input  logic [NUM_STAGES-1:ST_MEM0]                    cand_wr,
    input  logic [NUM_STAGES-1:ST_MEM0][REG_ADDR_W-1:0]    cand_rd,
    output logic [FW-1:0]                                  sel
);

    // Scan oldest to youngest so the youngest match overwrites.
    always_comb begin
        sel = FW'(FWD_RF);
        for (int s = NUM_STAGES - 1; s >= ST_MEM0; s--) begin
            if (rs_used && cand_vld[s] && cand_wr[s] &&
                (cand_rd[s] != '0) && (cand_rd[s] == rs)) begin
                sel = FW'(s - ST_EX);
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Central pipeline controller: valid bits, stage enables, stall/flush resolution, EX forwarding selects.
// Perf counters exist only when PIPE_PERF_CNT_EN is defined; otherwise their ports read 0.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int  NUM_STAGES = 5,
    parameter int  REG_ADDR_W = 5,
    parameter int  NUM_SRC    = 2,
    parameter int  CNT_W      = 32,
    localparam int FW         = $clog2(NUM_STAGES - 2)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          if_insn_vld,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]            id_rs_used,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic                          id_reg_wr,
    input  logic                          id_mem_rd,
    input  logic                          ex_busy,
    input  logic                          br_taken,
    input  logic                          mem_ready,
    output logic                          pc_en,
    output logic [NUM_STAGES-1:0]         stage_en,
    output logic [NUM_STAGES-1:0]         stage_vld,
    output logic                          flush,
    output logic [NUM_SRC*FW-1:0]         fwd_sel,
    output stall_cause_e                  stall_cause,
    output logic                          retire,
    output logic [CNT_W-1:0]              cyc_cnt,
    output logic [CNT_W-1:0]              ret_cnt,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic [CNT_W-1:0]              flush_cnt
);

    logic [NUM_STAGES-1:0]                      vld_q;
    logic [NUM_STAGES-1:ST_EX][REG_ADDR_W-1:0]  rd_q;
    logic [NUM_STAGES-1:ST_EX]                  wr_q;
    logic [NUM_STAGES-3:ST_EX]                  ld_q;
    logic [NUM_SRC*REG_ADDR_W-1:0]              ex_rs_q;
    logic [NUM_SRC-1:0]                         ex_used_q;

    logic [NUM_STAGES-1:0] freeze;
    logic [NUM_STAGES-1:0] bubble;
    logic                  load_use;

    // Only loads still short of the first data-return stage can cause a load-use hazard.
    always_comb begin
        load_use = 1'b0;
        for (int s = ST_EX; s <= NUM_STAGES - 3; s++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (vld_q[s] && ld_q[s] && (rd_q[s] != '0) && id_rs_used[i] &&
                    (rd_q[s] == id_rs[i*REG_ADDR_W +: REG_ADDR_W])) begin
                    load_use = 1'b1;
                end
            end
        end
        load_use = load_use & vld_q[ST_ID];
    end

    always_comb begin
        stall_cause = NONE;
        flush       = 1'b0;
        freeze      = '0;
        bubble      = '0;
        if (vld_q[ST_MEM0] && !mem_ready) begin
            stall_cause             = MEM_WAIT;
            freeze[ST_MEM0:ST_IF]   = '1;
            bubble[ST_MEM0+1]       = 1'b1;
        end else if (vld_q[ST_EX] && ex_busy) begin
            stall_cause             = EX_BUSY;
            freeze[ST_EX:ST_IF]     = '1;
            bubble[ST_MEM0]         = 1'b1;
        end else if (vld_q[ST_EX] && br_taken) begin
            stall_cause             = FLUSH;
            flush                   = 1'b1;
            bubble[ST_EX:ST_ID]     = '1;
        end else if (load_use) begin
            stall_cause             = LOAD_USE;
            freeze[ST_ID:ST_IF]     = '1;
            bubble[ST_EX]           = 1'b1;
        end else if (!if_insn_vld) begin
            stall_cause             = IF_WAIT;
            freeze[ST_IF]           = 1'b1;
            bubble[ST_ID]           = 1'b1;
        end
    end

    assign stage_en  = ~freeze;
    assign pc_en     = stage_en[ST_IF];
    assign stage_vld = vld_q;
    assign retire    = vld_q[NUM_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q     <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            ld_q      <= '0;
            ex_rs_q   <= '0;
            ex_used_q <= '0;
        end else begin
            // IF holds a live fetch once the PC has been loaded at least once.
            if (stage_en[ST_IF]) vld_q[ST_IF] <= 1'b1;
            if (stage_en[ST_ID]) vld_q[ST_ID] <= if_insn_vld & ~bubble[ST_ID];
            if (stage_en[ST_EX]) begin
                vld_q[ST_EX] <= vld_q[ST_ID] & ~bubble[ST_EX];
                rd_q[ST_EX]  <= id_rd;
                wr_q[ST_EX]  <= vld_q[ST_ID] & id_reg_wr & ~bubble[ST_EX];
                ld_q[ST_EX]  <= vld_q[ST_ID] & id_mem_rd & ~bubble[ST_EX];
                ex_rs_q      <= id_rs;
                ex_used_q    <= id_rs_used & {NUM_SRC{vld_q[ST_ID] & ~bubble[ST_EX]}};
            end
            for (int k = ST_MEM0; k < NUM_STAGES; k++) begin
                if (stage_en[k]) begin
                    vld_q[k] <= vld_q[k-1] & ~bubble[k];
                    rd_q[k]  <= rd_q[k-1];
                    wr_q[k]  <= wr_q[k-1] & ~bubble[k];
                end
            end
            for (int k = ST_MEM0; k <= NUM_STAGES - 3; k++) begin
                if (stage_en[k]) ld_q[k] <= ld_q[k-1] & ~bubble[k];
            end
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        pipe_fwd_sel #(
            .NUM_STAGES (NUM_STAGES),
            .REG_ADDR_W (REG_ADDR_W),
            .FW         (FW)
        ) u_fwd (
            .rs       (ex_rs_q[i*REG_ADDR_W +: REG_ADDR_W]),
            .rs_used  (ex_used_q[i]),
            .cand_vld (vld_q[NUM_STAGES-1:ST_MEM0]),
            .cand_wr  (wr_q[NUM_STAGES-1:ST_MEM0]),
            .cand_rd  (rd_q[NUM_STAGES-1:ST_MEM0]),
            .sel      (fwd_sel[i*FW +: FW])
        );
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc_cnt   <= '0;
            ret_cnt   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (retire)               ret_cnt   <= ret_cnt + CNT_W'(1);
            if (stall_cause != NONE)  stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush)                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`else
    assign cyc_cnt   = '0;
    assign ret_cnt   = '0;
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
